// File: rtl/pwm_duty_slew_pkg.sv
// Shared types for the PWM duty slew stage: FSM state constants and the debug view
// through which the FSM state is exposed.
package pwm_duty_slew_pkg;

    typedef logic [0:0] slew_state_t;

    localparam slew_state_t IDLE = 1'b0;
    localparam slew_state_t RAMP = 1'b1;

    typedef struct packed {
        slew_state_t state;
        logic        pend_v;
    } slew_dbg_t;

endpackage

// File: rtl/pwm_duty_step.sv
// Combinational next-duty calculation: moves duty toward target by at most step,
// or lands exactly on target (done) when step is 0 or the remaining distance fits.
module pwm_duty_step #(
    parameter int DW     = 4,
    parameter int STEP_W = DW
) (
    input  logic [DW-1:0]     duty,
    input  logic [DW-1:0]     target,
    input  logic [STEP_W-1:0] step,
    output logic [DW-1:0]     nxt,
    output logic              done
);

    // Wide enough for target-duty (DW+1 bits) and an unsigned step, plus a sign bit.
    localparam int CW = ((DW + 1 > STEP_W) ? DW + 1 : STEP_W) + 1;

    logic signed [CW-1:0] duty_w;
    logic signed [CW-1:0] tgt_w;
    logic signed [CW-1:0] step_w;
    logic signed [CW-1:0] diff_w;
    logic signed [CW-1:0] mag_w;
    logic signed [CW-1:0] sum_w;

    always_comb begin
        duty_w = {{(CW-DW){duty[DW-1]}}, duty};
        tgt_w  = {{(CW-DW){target[DW-1]}}, target};
        step_w = {{(CW-STEP_W){1'b0}}, step};
        diff_w = tgt_w - duty_w;
        mag_w  = diff_w[CW-1] ? -diff_w : diff_w;
        done   = (step == '0) || (mag_w <= step_w);
        sum_w  = diff_w[CW-1] ? (duty_w - step_w) : (duty_w + step_w);
        // When not done the partial step stays strictly between duty and target, so it fits DW bits.
        nxt    = done ? target : DW'(sum_w);
    end

endmodule

// File: rtl/pwm_duty_slew.sv
// Slews a signed PWM duty toward a target by at most `step` per PWM period (on `co`),
// holding one queued target. Optional kill input enabled by the PWM_SLEW_KILL_EN macro.
module pwm_duty_slew
    import pwm_duty_slew_pkg::*;
#(
    parameter int DW     = 4,
    parameter int STEP_W = DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     tgt,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic [STEP_W-1:0] step,
    input  logic              co,
`ifdef PWM_SLEW_KILL_EN
    input  logic              kill,
`endif
    output logic [DW-1:0]     duty,
    output logic              settled
);

    logic [DW-1:0] duty_q, duty_d;
    logic [DW-1:0] target_q, target_d;
    logic [DW-1:0] pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    slew_state_t   state_q, state_d;

    logic          kill_w;
    logic          accept;
    logic [DW-1:0] step_nxt;
    logic          step_done;
    slew_dbg_t     dbg;

`ifdef PWM_SLEW_KILL_EN
    assign kill_w = kill;
`else
    assign kill_w = 1'b0;
`endif

    // Handshake: a word transfers on a cycle where tgt_valid and tgt_ready are both high;
    // ready depends only on registered state, reset and kill, never on tgt_valid.
    assign tgt_ready = rst & ~pend_v_q & ~kill_w;
    assign accept    = tgt_valid & tgt_ready;

    pwm_duty_step #(
        .DW     (DW),
        .STEP_W (STEP_W)
    ) u_step (
        .duty   (duty_q),
        .target (target_q),
        .step   (step),
        .nxt    (step_nxt),
        .done   (step_done)
    );

    always_comb begin
        duty_d   = duty_q;
        target_d = target_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        state_d  = state_q;
        if (kill_w) begin
            duty_d   = '0;
            target_d = '0;
            pend_v_d = 1'b0;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_v_q) begin
                        target_d = pend_q;
                        pend_v_d = 1'b0;
                        state_d  = RAMP;
                    end else if (accept && (tgt != duty_q)) begin
                        target_d = tgt;
                        state_d  = RAMP;
                    end
                end
                default: begin
                    if (accept) begin
                        pend_d   = tgt;
                        pend_v_d = 1'b1;
                    end
                    // Accept and a pending-promotion never coincide: accept needs pend_v_q low.
                    if (co) begin
                        duty_d = step_nxt;
                        if (step_done) begin
                            if (pend_v_q) begin
                                target_d = pend_q;
                                pend_v_d = 1'b0;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            duty_q   <= '0;
            target_q <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            state_q  <= IDLE;
        end else begin
            duty_q   <= duty_d;
            target_q <= target_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            state_q  <= state_d;
        end
    end

    assign dbg     = '{state: state_q, pend_v: pend_v_q};
    assign duty    = duty_q;
    assign settled = (dbg.state == IDLE) & ~dbg.pend_v;

endmodule

// File: tb/tb_pwm_duty_slew.sv
// Self-checking bench for pwm_duty_slew (DW=4): directed ramps, queueing, edge cases
// and a randomized run against an integer/queue reference model.
module tb_pwm_duty_slew;

    logic       clk;
    logic       rst;
    logic [3:0] tgt;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] step;
    logic       co;
    logic       kill;
    logic [3:0] duty;
    logic       settled;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];
    logic [3:0] exp_v;

    // Reference model: integer duty/target, a queue of pending targets, ramp flag.
    int m_duty;
    int m_target;
    int m_pend[$];
    bit m_ramp;

    pwm_duty_slew #(.DW(4), .STEP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt       (tgt),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .step      (step),
        .co        (co),
`ifdef PWM_SLEW_KILL_EN
        .kill      (kill),
`endif
        .duty      (duty),
        .settled   (settled)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        m_duty = 0;
        m_target = 0;
        m_pend.delete();
        m_ramp = 1'b0;
    endfunction

    function automatic void model_edge(bit acc, int t, bit c, bit k, int s);
        bit had;
        int diff;
        int mag;
        if (k) begin
            model_clear();
            return;
        end
        if (!m_ramp) begin
            if (m_pend.size() != 0) begin
                m_target = m_pend.pop_front();
                m_ramp = 1'b1;
            end else if (acc && (t != m_duty)) begin
                m_target = t;
                m_ramp = 1'b1;
            end
        end else begin
            had = (m_pend.size() != 0);
            if (acc) m_pend.push_back(t);
            if (c) begin
                diff = m_target - m_duty;
                mag = (diff < 0) ? -diff : diff;
                if (s == 0 || mag <= s) begin
                    m_duty = m_target;
                    if (had) m_target = m_pend.pop_front();
                    else m_ramp = 1'b0;
                end else begin
                    m_duty = m_duty + ((diff < 0) ? -s : s);
                end
            end
        end
    endfunction

    // driver: one clock with the given inputs; outputs settle 1 time unit after the edge
    task automatic cycle(input bit v, input int t, input bit c, input bit k);
        bit acc;
        tgt_valid = v;
        tgt = 4'(t);
        co = c;
        kill = k;
        acc = v && !k && (m_pend.size() == 0);
        @(posedge clk);
        model_edge(acc, int'($signed(4'(t))), c, k, int'(step));
        #1;
        tgt_valid = 1'b0;
        co = 1'b0;
        kill = 1'b0;
    endtask

    task automatic run_co(input int gap);
        repeat (gap) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tgt_valid = 1'b1;
        tgt = 4'd5;
        co = 1'b1;
        kill = 1'b0;
        step = 4'd2;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (tgt_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready got=%b exp=0", tgt_ready);
            end
        end
        checks++;
        if (duty !== 4'd0) begin
            errors++;
            $display("FAIL reset_duty got=%0d exp=0", $signed(duty));
        end
        checks++;
        if (settled !== 1'b1) begin
            errors++;
            $display("FAIL reset_settled got=%b exp=1", settled);
        end
        tgt_valid = 1'b0;
        co = 1'b0;
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (tgt_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=1", tgt_ready);
        end
    endtask

    task automatic test_ramp_up();
        step = 4'd2;
        exp_q = '{4'd2, 4'd4, 4'd6, 4'd7};
        cycle(1, 7, 0, 0);
        checks++;
        if (duty !== 4'd0 || settled !== 1'b0) begin
            errors++;
            $display("FAIL up_accept duty=%0d settled=%b exp duty=0 settled=0", $signed(duty), settled);
        end
        while (exp_q.size() != 0) begin
            run_co(15);
            exp_v = exp_q.pop_front();
            checks++;
            if (duty !== exp_v) begin
                errors++;
                $display("FAIL up_duty got=%0d exp=%0d", $signed(duty), $signed(exp_v));
            end
        end
        checks++;
        if (settled !== 1'b1) begin
            errors++;
            $display("FAIL up_settled got=%b exp=1", settled);
        end
    endtask

    task automatic test_ramp_down();
        step = 4'd3;
        exp_q = '{4'd4, 4'd1, 4'hE, 4'hB, 4'h8};
        cycle(1, -8, 0, 0);
        while (exp_q.size() != 0) begin
            run_co(15);
            exp_v = exp_q.pop_front();
            checks++;
            if (duty !== exp_v) begin
                errors++;
                $display("FAIL down_duty got=%0d exp=%0d", $signed(duty), $signed(exp_v));
            end
        end
        run_co(3);
        checks++;
        if (duty !== 4'h8 || settled !== 1'b1) begin
            errors++;
            $display("FAIL down_hold duty=%0d settled=%b exp duty=-8 settled=1", $signed(duty), settled);
        end
    endtask

    task automatic test_queue();
        step = 4'd3;
        exp_q = '{4'hB, 4'hE, 4'd1, 4'd4, 4'd7, 4'd4, 4'd1, 4'hE, 4'hD};
        cycle(1, 7, 0, 0);
        run_co(3);
        exp_v = exp_q.pop_front();
        checks++;
        if (duty !== exp_v) begin
            errors++;
            $display("FAIL queue_first got=%0d exp=%0d", $signed(duty), $signed(exp_v));
        end
        cycle(1, -3, 0, 0);
        checks++;
        if (tgt_ready !== 1'b0) begin
            errors++;
            $display("FAIL queue_ready got=%b exp=0", tgt_ready);
        end
        while (exp_q.size() != 0) begin
            run_co(3);
            exp_v = exp_q.pop_front();
            checks++;
            if (duty !== exp_v) begin
                errors++;
                $display("FAIL queue_duty got=%0d exp=%0d", $signed(duty), $signed(exp_v));
            end
            if (exp_v == 4'd7) begin
                checks++;
                if (settled !== 1'b0 || tgt_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL queue_no_idle settled=%b ready=%b exp settled=0 ready=1", settled, tgt_ready);
                end
            end
        end
        checks++;
        if (settled !== 1'b1) begin
            errors++;
            $display("FAIL queue_settled got=%b exp=1", settled);
        end
    endtask

    task automatic test_edge_cases();
        step = 4'd0;
        cycle(1, -8, 0, 0);
        run_co(2);
        checks++;
        if (duty !== 4'h8 || settled !== 1'b1) begin
            errors++;
            $display("FAIL step0_jump duty=%0d settled=%b exp duty=-8 settled=1", $signed(duty), settled);
        end
        cycle(1, -8, 0, 0);
        checks++;
        if (settled !== 1'b1 || duty !== 4'h8) begin
            errors++;
            $display("FAIL same_tgt settled=%b duty=%0d exp settled=1 duty=-8", settled, $signed(duty));
        end
        run_co(1);
        checks++;
        if (duty !== 4'h8) begin
            errors++;
            $display("FAIL idle_co_ignored got=%0d exp=-8", $signed(duty));
        end
        cycle(1, 5, 0, 0);
        cycle(1, 2, 1, 0);
        checks++;
        if (duty !== 4'd5 || settled !== 1'b0 || tgt_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_on_done duty=%0d settled=%b ready=%b exp duty=5 settled=0 ready=0",
                     $signed(duty), settled, tgt_ready);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (duty !== 4'd5 || settled !== 1'b0 || tgt_ready !== 1'b1) begin
            errors++;
            $display("FAIL promote duty=%0d settled=%b ready=%b exp duty=5 settled=0 ready=1",
                     $signed(duty), settled, tgt_ready);
        end
        run_co(1);
        checks++;
        if (duty !== 4'd2 || settled !== 1'b1) begin
            errors++;
            $display("FAIL promote_done duty=%0d settled=%b exp duty=2 settled=1", $signed(duty), settled);
        end
    endtask

    task automatic test_reset_mid();
        step = 4'd1;
        cycle(1, 7, 0, 0);
        run_co(0);
        checks++;
        if (duty !== 4'd3) begin
            errors++;
            $display("FAIL mid_pre got=%0d exp=3", $signed(duty));
        end
        cycle(1, -1, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        model_clear();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (duty !== 4'd0 || settled !== 1'b1 || tgt_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset duty=%0d settled=%b ready=%b exp duty=0 settled=1 ready=1",
                     $signed(duty), settled, tgt_ready);
        end
    endtask

`ifdef PWM_SLEW_KILL_EN
    task automatic test_kill();
        step = 4'd2;
        cycle(1, 7, 0, 0);
        run_co(1);
        cycle(1, -3, 0, 0);
        run_co(1);
        checks++;
        if (duty !== 4'd4 || tgt_ready !== 1'b0) begin
            errors++;
            $display("FAIL kill_pre duty=%0d ready=%b exp duty=4 ready=0", $signed(duty), tgt_ready);
        end
        cycle(0, 0, 0, 1);
        checks++;
        if (duty !== 4'd0 || settled !== 1'b1) begin
            errors++;
            $display("FAIL kill duty=%0d settled=%b exp duty=0 settled=1", $signed(duty), settled);
        end
        kill = 1'b1;
        #1;
        checks++;
        if (tgt_ready !== 1'b0) begin
            errors++;
            $display("FAIL kill_ready got=%b exp=0", tgt_ready);
        end
        kill = 1'b0;
        run_co(1);
        run_co(1);
        checks++;
        if (duty !== 4'd0 || settled !== 1'b1) begin
            errors++;
            $display("FAIL kill_no_resume duty=%0d settled=%b exp duty=0 settled=1", $signed(duty), settled);
        end
    endtask
`endif

    task automatic test_random();
        bit v;
        bit c;
        int t;
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) step = 4'($urandom_range(0, 15));
            v = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 3) == 0);
            t = $urandom_range(0, 15) - 8;
            cycle(v, t, c, 0);
            checks++;
            if (duty !== 4'(m_duty) || settled !== (!m_ramp && m_pend.size() == 0) ||
                tgt_ready !== (m_pend.size() == 0)) begin
                errors++;
                $display("FAIL random[%0d] duty=%0d settled=%b ready=%b exp duty=%0d settled=%b ready=%b",
                         i, $signed(duty), settled, tgt_ready, m_duty,
                         (!m_ramp && m_pend.size() == 0), (m_pend.size() == 0));
            end
        end
    endtask

    initial begin
        kill = 1'b0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_queue();
        test_edge_cases();
        test_reset_mid();
`ifdef PWM_SLEW_KILL_EN
        test_kill();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
